// File: rtl/md5_hash_matcher.sv
// md5_hash_matcher: consumer end of the MD5 cracking pipeline.
// A delay line shadows every guess fed into the pipeline. Each hash that
// comes out of the pipeline is compared with the host-loaded target digest,
// and on a hit the guess that produced it is captured for the host.
// Optional build macro MD5_MATCH_COUNT_EN adds a saturating 48-bit
// checked_count output that counts the guesses compared while armed.

module md5_hash_matcher #(
    parameter int PIPE_LATENCY = 66
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         guess_valid,
    input  logic [127:0] guess,
    input  logic [3:0]   guesslen,
    input  logic [31:0]  hashA,
    input  logic [31:0]  hashB,
    input  logic [31:0]  hashC,
    input  logic [31:0]  hashD,
    input  logic         target_we,
    input  logic [127:0] target,
    input  logic         match_ack,
    output logic         armed,
    output logic         match_valid,
    output logic [127:0] match_guess,
    output logic [3:0]   match_len,
    output logic         overflow
`ifdef MD5_MATCH_COUNT_EN
    ,
    output logic [47:0]  checked_count
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] MATCHED = 2'd2;

    logic [1:0]              state;
    logic [127:0]            target_reg;
    logic [PIPE_LATENCY-1:0] dly_valid;
    logic [127:0]            dly_guess [PIPE_LATENCY];
    logic [3:0]              dly_len   [PIPE_LATENCY];
    logic                    out_valid;
    logic                    hit;

    assign out_valid   = dly_valid[PIPE_LATENCY-1];
    assign armed       = (state != IDLE);
    assign match_valid = (state == MATCHED);
    assign hit         = out_valid && armed &&
                         ({hashA, hashB, hashC, hashD} == target_reg);

    // Valid bits of the delay line; a new target discards everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_valid <= '0;
        end else if (target_we) begin
            dly_valid <= '0;
        end else begin
            dly_valid[0] <= guess_valid;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                dly_valid[i] <= dly_valid[i-1];
            end
        end
    end

    // Guess payload of the delay line; only meaningful where its valid bit is set
    always_ff @(posedge clk) begin
        dly_guess[0] <= guess;
        dly_len[0]   <= guesslen;
        for (int i = 1; i < PIPE_LATENCY; i++) begin
            dly_guess[i] <= dly_guess[i-1];
            dly_len[i]   <= dly_len[i-1];
        end
    end

    // Match FSM with target loading; target_we outranks hit and match_ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            target_reg  <= '0;
            match_guess <= '0;
            match_len   <= '0;
            overflow    <= 1'b0;
        end else if (target_we) begin
            state      <= ARMED;
            target_reg <= target;
            overflow   <= 1'b0;
        end else begin
            case (state)
                ARMED: begin
                    if (hit) begin
                        state       <= MATCHED;
                        match_guess <= dly_guess[PIPE_LATENCY-1];
                        match_len   <= dly_len[PIPE_LATENCY-1];
                    end
                end
                MATCHED: begin
                    if (hit && match_ack) begin
                        match_guess <= dly_guess[PIPE_LATENCY-1];
                        match_len   <= dly_len[PIPE_LATENCY-1];
                    end else if (hit) begin
                        overflow <= 1'b1;
                    end else if (match_ack) begin
                        state <= ARMED;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MD5_MATCH_COUNT_EN
    // Saturating count of real guesses compared while armed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checked_count <= '0;
        end else if (target_we) begin
            checked_count <= '0;
        end else if (out_valid && armed && (checked_count != '1)) begin
            checked_count <= checked_count + 48'd1;
        end
    end
`endif

endmodule
